// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller and datapath.
package mult_pkg;

   localparam int unsigned WORD_LENGTH_DEF = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      TEST  = 3'd3,
      ADD   = 3'd4,
      SHIFT = 3'd5,
      DONE  = 3'd6,
      ABORT = 3'd7
   } state_t;

endpackage

// File: rtl/shift_mult_sequencer_iter_counter.sv
// Iteration counter: counts completed shifts and flags the last iteration.
module iter_counter #(
   parameter int unsigned WORD_LENGTH = 8,
   parameter int unsigned CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 terminal
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WORD_LENGTH - 1);

   logic [CNT_WIDTH-1:0] next_count;

   // Next count: clear has priority over increment.
   always_comb begin
      next_count = count;
      if (clear) begin
         next_count = '0;
      end else if (inc) begin
         next_count = count + CNT_WIDTH'(1);
      end
   end

   // Count register; terminal is registered alongside so it tracks count exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         terminal <= 1'b0;
      end else begin
         count    <= next_count;
         terminal <= (next_count == LAST);
      end
   end

endmodule

// File: rtl/shift_mult_sequencer.sv
// Control FSM sequencing the shift-add multiplier datapath strobes.
module shift_mult_sequencer
   import mult_pkg::*;
#(
   parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic                                  mplr_bit,
   output logic                                  sr_clear,
   output logic                                  sr_load,
   output logic                                  sr_shift,
   output logic                                  acc_clear,
   output logic                                  acc_add,
   output logic                                  busy,
   output logic                                  done,
   output logic [$clog2(WORD_LENGTH + 1)-1:0]    iter_count
);

   localparam int unsigned CNT_WIDTH = $clog2(WORD_LENGTH + 1);

   state_t state;
   state_t next_state;
   logic   terminal;
   logic   abortable;

   logic   sr_clear_d, sr_load_d, sr_shift_d, acc_clear_d, acc_add_d, busy_d, done_d;

   iter_counter #(
      .WORD_LENGTH (WORD_LENGTH),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_iter_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == CLEAR),
      .inc      (state == SHIFT),
      .count    (iter_count),
      .terminal (terminal)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; abort overrides every transition of an active operation.
   always_comb begin
      next_state = state;
      abortable  = 1'b0;
      unique case (state)
         IDLE:  if (start) next_state = CLEAR;
         CLEAR: begin next_state = LOAD;  abortable = 1'b1; end
         LOAD:  begin next_state = TEST;  abortable = 1'b1; end
         TEST:  begin next_state = mplr_bit ? ADD : SHIFT; abortable = 1'b1; end
         ADD:   begin next_state = SHIFT; abortable = 1'b1; end
         SHIFT: begin next_state = terminal ? DONE : TEST; abortable = 1'b1; end
         DONE:  next_state = IDLE;
         ABORT: next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (abort && abortable) begin
         next_state = ABORT;
      end
   end

   // Moore decode of the upcoming state so outputs can be registered without extra latency.
   always_comb begin
      sr_clear_d  = 1'b0;
      sr_load_d   = 1'b0;
      sr_shift_d  = 1'b0;
      acc_clear_d = 1'b0;
      acc_add_d   = 1'b0;
      done_d      = 1'b0;
      busy_d      = (next_state != IDLE);
      unique case (next_state)
         CLEAR, ABORT: begin sr_clear_d = 1'b1; acc_clear_d = 1'b1; end
         LOAD:  sr_load_d  = 1'b1;
         ADD:   acc_add_d  = 1'b1;
         SHIFT: sr_shift_d = 1'b1;
         DONE:  done_d     = 1'b1;
         default: ;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_clear  <= 1'b0;
         sr_load   <= 1'b0;
         sr_shift  <= 1'b0;
         acc_clear <= 1'b0;
         acc_add   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         sr_clear  <= sr_clear_d;
         sr_load   <= sr_load_d;
         sr_shift  <= sr_shift_d;
         acc_clear <= acc_clear_d;
         acc_add   <= acc_add_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_shift_mult_sequencer.sv
// Directed testbench for shift_mult_sequencer with a small datapath model and scoreboard.
module tb_shift_mult_sequencer;

   localparam int unsigned WL = 8;
   localparam int unsigned CW = $clog2(WL + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          mplr_bit;
   logic          sr_clear, sr_load, sr_shift, acc_clear, acc_add, busy, done;
   logic [CW-1:0] iter_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int lat;
      int prod;
      int adds;
   } exp_t;
   exp_t sb[$];

   logic [7:0]  op_mcand = '0;
   logic [7:0]  op_mplr  = '0;
   logic [7:0]  mplr_sr;
   logic [15:0] acc;

   shift_mult_sequencer #(.WORD_LENGTH(WL)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .mplr_bit   (mplr_bit),
      .sr_clear   (sr_clear),
      .sr_load    (sr_load),
      .sr_shift   (sr_shift),
      .acc_clear  (acc_clear),
      .acc_add    (acc_add),
      .busy       (busy),
      .done       (done),
      .iter_count (iter_count)
   );

   always #5 clk = ~clk;

   // Datapath model driven by the controller strobes.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mplr_sr <= '0;
         acc     <= '0;
      end else begin
         if (sr_clear)  mplr_sr <= '0;
         if (acc_clear) acc <= '0;
         if (sr_load)   mplr_sr <= op_mplr;
         if (acc_add)   acc <= acc + (16'(op_mcand) << iter_count);
         if (sr_shift)  mplr_sr <= mplr_sr >> 1;
      end
   end
   assign mplr_bit = mplr_sr[0];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_outs"}, int'({sr_clear, sr_load, sr_shift, acc_clear, acc_add, busy, done}), 0);
   endtask

   // Drive start for one sampled edge; optionally record the expected result.
   task automatic launch(input logic [7:0] mcand, input logic [7:0] mplr, input bit expect_done);
      exp_t e;
      @(negedge clk);
      op_mcand = mcand;
      op_mplr  = mplr;
      start    = 1'b1;
      if (expect_done) begin
         e.lat  = 3 + 2 * WL + $countones(mplr);
         e.prod = int'(mcand) * int'(mplr);
         e.adds = $countones(mplr);
         sb.push_back(e);
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Follow an operation whose start was just sampled, until done or a cycle budget expires.
   task automatic run_to_done(input int pulse_at, input int hold_from);
      int   k = 0;
      int   adds = 0;
      int   shifts = 0;
      bit   prev_add = 1'b0;
      bit   seen = 1'b0;
      exp_t e;
      while (!seen && k < 100) begin
         @(negedge clk);
         k++;
         if (k == pulse_at)     start = 1'b1;
         if (k == pulse_at + 1) start = 1'b0;
         if (k == hold_from)    start = 1'b1;
         if (k == 1) check("clear_cycle1", int'(sr_clear & acc_clear), 1);
         if (k == 2) check("load_cycle2", int'(sr_load), 1);
         check("busy_active", int'(busy), 1);
         check("clear_pair", int'(sr_clear), int'(acc_clear));
         check("strobe_excl", int'(int'(sr_clear) + int'(sr_load) + int'(sr_shift) + int'(acc_add) + int'(done) <= 1), 1);
         if (prev_add) check("add_then_shift", int'(sr_shift), 1);
         prev_add = acc_add;
         adds    += int'(acc_add);
         shifts  += int'(sr_shift);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         check("done_timeout", 0, 1);
      end else if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("done_latency", k, e.lat);
         check("product", int'(acc), e.prod);
         check("add_count", adds, e.adds);
         check("shift_count", shifts, WL);
         check("iter_count_done", int'(iter_count), WL);
      end
   endtask

   initial begin
      int  k;
      int  shifts;
      bit  hit;
      bit  quiet;

      // Reset state
      repeat (2) @(negedge clk);
      check_quiet("reset");
      check("reset_iter", int'(iter_count), 0);
      reset = 1'b1;
      @(negedge clk);
      check_quiet("idle_after_reset");

      // Multiplier 0x00: minimum latency
      launch(8'd13, 8'h00, 1'b1);
      run_to_done(-10, -10);
      @(negedge clk);
      check("idle_keeps_iter", int'(iter_count), WL);
      check_quiet("idle_after_done");

      // Multiplier 0xFF: maximum latency
      launch(8'd200, 8'hFF, 1'b1);
      run_to_done(-10, -10);

      // Multiplier 0x05: product 13*5
      launch(8'd13, 8'h05, 1'b1);
      run_to_done(-10, -10);

      // Abort in the 3rd SHIFT
      launch(8'd13, 8'h00, 1'b0);
      k = 0; shifts = 0; hit = 1'b0;
      while (!hit && k < 40) begin
         @(negedge clk);
         k++;
         if (sr_shift) shifts++;
         if (shifts == 3) hit = 1'b1;
      end
      check("abort_reach_shift3", int'(hit), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_clears", int'(sr_clear & acc_clear), 1);
      check("abort_busy", int'(busy), 1);
      check("abort_no_done", int'(done), 0);
      check("abort_iter", int'(iter_count), 3);
      @(negedge clk);
      check_quiet("after_abort");
      quiet = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) quiet = 1'b0;
      end
      check("abort_stays_idle", int'(quiet), 1);

      // Start pulse mid-operation ignored; start held through DONE relaunches
      launch(8'd3, 8'h01, 1'b1);
      run_to_done(5, 17);
      op_mcand = 8'd7;
      op_mplr  = 8'hA0;
      begin
         exp_t e;
         e.lat  = 3 + 2 * WL + 2;
         e.prod = 7 * 160;
         e.adds = 2;
         sb.push_back(e);
      end
      @(negedge clk);
      check("gap_idle_busy", int'(busy), 0);
      check("gap_idle_done", int'(done), 0);
      @(posedge clk);
      #1 start = 1'b0;
      run_to_done(-10, -10);

      // Reset during ADD
      launch(8'd9, 8'hFF, 1'b0);
      k = 0; hit = 1'b0;
      while (!hit && k < 20) begin
         @(negedge clk);
         k++;
         if (acc_add) hit = 1'b1;
      end
      check("reach_add", int'(hit), 1);
      #2 reset = 1'b0;
      #1;
      check_quiet("async_reset");
      check("async_reset_iter", int'(iter_count), 0);
      @(negedge clk);
      reset = 1'b1;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (busy || done || sr_clear || sr_load || sr_shift || acc_add || acc_clear) quiet = 1'b0;
      end
      check("idle_after_reset_release", int'(quiet), 1);

      // Normal operation after reset
      launch(8'd13, 8'h05, 1'b1);
      run_to_done(-10, -10);
      check("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
